// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver with glitch-filtered clock, frame decoder, E0/F0
// prefix tracking and an event FIFO.
//
// Ports:
//   clk, reset            - system clock, asynchronous active-high reset
//   ps2_clk, ps2_data     - raw asynchronous PS/2 lines
//   out_valid, out_ready  - FIFO head handshake (pop on valid & ready)
//   out_code              - scan code at FIFO head
//   out_break, out_ext    - head entry was preceded by F0 / E0
//   parity_err, frame_err - single-cycle error pulses (timeout uses frame_err)
//   overflow              - single-cycle pulse when an entry is dropped
//   fifo_count            - current FIFO occupancy
module ps2_keyboard_rx #(
   parameter int unsigned FILTER_CYCLES  = 8,
   parameter int unsigned TIMEOUT_CYCLES = 4095,
   parameter int unsigned FIFO_AW        = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ps2_clk,
   input  logic               ps2_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [7:0]         out_code,
   output logic               out_break,
   output logic               out_ext,
   output logic               parity_err,
   output logic               frame_err,
   output logic               overflow,
   output logic [FIFO_AW:0]   fifo_count
);

   localparam int unsigned FW    = $clog2(FILTER_CYCLES + 1);
   localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned DEPTH = 1 << FIFO_AW;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   // Synchronisers and clock filter
   logic [1:0]    clk_s;
   logic [1:0]    dat_s;
   logic          filt_clk;
   logic [FW-1:0] fcnt;
   logic          fall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_s    <= 2'b11;
         dat_s    <= 2'b11;
         filt_clk <= 1'b1;
         fcnt     <= '0;
         fall     <= 1'b0;
      end else begin
         clk_s <= {clk_s[0], ps2_clk};
         dat_s <= {dat_s[0], ps2_data};
         fall  <= 1'b0;
         if (clk_s[1] != filt_clk) begin
            if (fcnt == FW'(FILTER_CYCLES - 1)) begin
               filt_clk <= clk_s[1];
               fcnt     <= '0;
               // old level 1 means this change is a falling edge
               fall     <= filt_clk;
            end else begin
               fcnt <= fcnt + 1'b1;
            end
         end else begin
            fcnt <= '0;
         end
      end
   end

   // Frame decoder
   state_t        state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          par_bit;
   logic [TW-1:0] tcnt;
   logic          ext_pend;
   logic          brk_pend;
   logic          push_req;
   logic [9:0]    push_data;
   logic          par_ok;
   logic          stop_ok;

   assign par_ok  = ^{shreg, par_bit};
   assign stop_ok = dat_s[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         tcnt       <= '0;
         ext_pend   <= 1'b0;
         brk_pend   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         push_req   <= 1'b0;
         push_data  <= '0;
      end else begin
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         push_req   <= 1'b0;
         if (state != IDLE && !fall && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state     <= IDLE;
            tcnt      <= '0;
            frame_err <= 1'b1;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
         end else begin
            if (state != IDLE)
               tcnt <= fall ? '0 : tcnt + 1'b1;
            if (fall) begin
               case (state)
                  IDLE: begin
                     if (!dat_s[1]) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        tcnt    <= '0;
                     end
                  end
                  DATA: begin
                     shreg   <= {dat_s[1], shreg[7:1]};
                     bit_cnt <= bit_cnt + 1'b1;
                     if (bit_cnt == 3'd7)
                        state <= PARITY;
                  end
                  PARITY: begin
                     par_bit <= dat_s[1];
                     state   <= STOP;
                  end
                  STOP: begin
                     state      <= IDLE;
                     tcnt       <= '0;
                     parity_err <= ~par_ok;
                     frame_err  <= ~stop_ok;
                     if (par_ok && stop_ok) begin
                        if (shreg == 8'hE0) begin
                           ext_pend <= 1'b1;
                        end else if (shreg == 8'hF0) begin
                           brk_pend <= 1'b1;
                        end else begin
                           push_req  <= 1'b1;
                           push_data <= {shreg, brk_pend, ext_pend};
                           ext_pend  <= 1'b0;
                           brk_pend  <= 1'b0;
                        end
                     end else begin
                        ext_pend <= 1'b0;
                        brk_pend <= 1'b0;
                     end
                  end
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end

   // Event FIFO
   logic [9:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic               full;
   logic               pop;
   logic               push_ok;
   logic [9:0]         head;

   assign out_valid = (fifo_count != '0);
   assign full      = (fifo_count == (FIFO_AW+1)'(DEPTH));
   assign pop       = out_valid & out_ready;
   // a push into a full FIFO is fine when the same cycle frees a slot
   assign push_ok   = push_req & (~full | pop);
   assign head      = mem[rd_ptr];
   assign out_code  = out_valid ? head[9:2] : '0;
   assign out_break = out_valid & head[1];
   assign out_ext   = out_valid & head[0];

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         overflow <= push_req & full & ~pop;
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed self-checking bench for ps2_keyboard_rx.
module tb_ps2_keyboard_rx;

   logic       clk = 1'b0;
   logic       reset;
   logic       ps2_clk;
   logic       ps2_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_code;
   logic       out_break;
   logic       out_ext;
   logic       parity_err;
   logic       frame_err;
   logic       overflow;
   logic [3:0] fifo_count;

   int checks   = 0;
   int failures = 0;
   int perr_n   = 0;
   int ferr_n   = 0;
   int ovf_n    = 0;
   logic [9:0] popq[$];

   ps2_keyboard_rx #(
      .FILTER_CYCLES (8),
      .TIMEOUT_CYCLES(400),
      .FIFO_AW       (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_code  (out_code),
      .out_break (out_break),
      .out_ext   (out_ext),
      .parity_err(parity_err),
      .frame_err (frame_err),
      .overflow  (overflow),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (parity_err) perr_n++;
      if (frame_err)  ferr_n++;
      if (overflow)   ovf_n++;
      if (out_valid && out_ready) popq.push_back({out_code, out_break, out_ext});
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic ps2_bit(input logic b, input bit glitch);
      ps2_data = b;
      if (glitch) begin
         wait_cyc(3);
         ps2_clk = 1'b0;
         wait_cyc(7);
         ps2_clk = 1'b1;
         wait_cyc(5);
      end else begin
         wait_cyc(15);
      end
      ps2_clk = 1'b0;
      wait_cyc(30);
      ps2_clk = 1'b1;
      wait_cyc(15);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int glitch_bit);
      logic [10:0] bits;
      bits[0]   = 1'b0;
      bits[8:1] = b;
      bits[9]   = ~(^b) ^ bad_par;
      bits[10]  = ~bad_stop;
      for (int i = 0; i < 11; i++)
         ps2_bit(bits[i], (i == glitch_bit));
      ps2_data = 1'b1;
      wait_cyc(20);
   endtask

   task automatic pop_one();
      out_ready = 1'b1;
      wait_cyc(1);
      out_ready = 1'b0;
      wait_cyc(1);
   endtask

   initial begin
      reset     = 1'b1;
      ps2_clk   = 1'b1;
      ps2_data  = 1'b1;
      out_ready = 1'b0;
      wait_cyc(5);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_count", 32'(fifo_count), 0);
      chk("rst_code", 32'(out_code), 0);
      chk("rst_errs", 32'({parity_err, frame_err, overflow}), 0);
      reset = 1'b0;
      wait_cyc(30);
      chk("rst_no_false_edge", 32'(dut.state), 0);

      // single good frame, consumer always ready
      out_ready = 1'b1;
      popq.delete();
      send_frame(8'h1C, 0, 0, -1);
      chk("t1_entries", popq.size(), 1);
      chk("t1_entry", (popq.size() > 0) ? 32'(popq[0]) : 32'hDEAD, 32'({8'h1C, 2'b00}));
      chk("t1_perr", perr_n, 0);
      chk("t1_ferr", ferr_n, 0);
      out_ready = 1'b0;
      popq.delete();

      // extended break sequence
      send_frame(8'hE0, 0, 0, -1);
      send_frame(8'hF0, 0, 0, -1);
      chk("t2_prefix_no_push", 32'(fifo_count), 0);
      send_frame(8'h74, 0, 0, -1);
      chk("t2_count", 32'(fifo_count), 1);
      chk("t2_code", 32'(out_code), 32'h74);
      chk("t2_break", 32'(out_break), 1);
      chk("t2_ext", 32'(out_ext), 1);
      pop_one();
      chk("t2_empty", 32'(out_valid), 0);

      // parity error, then errored frame clears pending break
      send_frame(8'h1C, 1, 0, -1);
      chk("t3_perr", perr_n, 1);
      chk("t3_no_entry", 32'(fifo_count), 0);
      send_frame(8'hF0, 0, 0, -1);
      send_frame(8'h33, 0, 1, -1);
      chk("t3_ferr", ferr_n, 1);
      chk("t3_no_entry2", 32'(fifo_count), 0);
      send_frame(8'h1C, 0, 0, -1);
      chk("t3_count", 32'(fifo_count), 1);
      chk("t3_code", 32'(out_code), 32'h1C);
      chk("t3_break", 32'(out_break), 0);
      pop_one();

      // partial frame then timeout
      ps2_bit(1'b0, 0);
      ps2_bit(1'b1, 0);
      ps2_bit(1'b0, 0);
      ps2_bit(1'b1, 0);
      ps2_data = 1'b1;
      wait_cyc(450);
      chk("t4_ferr", ferr_n, 2);
      chk("t4_idle", 32'(dut.state), 0);
      chk("t4_no_entry", 32'(fifo_count), 0);
      send_frame(8'h5A, 0, 0, -1);
      chk("t4_code", 32'(out_code), 32'h5A);
      chk("t4_count", 32'(fifo_count), 1);
      pop_one();

      // short low glitch on ps2_clk during data bit 4
      send_frame(8'h3B, 0, 0, 5);
      chk("t6_code", 32'(out_code), 32'h3B);
      chk("t6_count", 32'(fifo_count), 1);
      chk("t6_perr", perr_n, 1);
      chk("t6_ferr", ferr_n, 2);
      pop_one();

      // overflow
      for (int i = 1; i <= 9; i++)
         send_frame(8'(i), 0, 0, -1);
      chk("t5_count", 32'(fifo_count), 8);
      chk("t5_ovf", ovf_n, 1);
      for (int i = 1; i <= 8; i++) begin
         chk("t5_valid", 32'(out_valid), 1);
         chk("t5_entry", 32'({out_code, out_break, out_ext}), 32'({8'(i), 2'b00}));
         pop_one();
      end
      chk("t5_drained", 32'(fifo_count), 0);
      chk("t5_perr", perr_n, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      failures++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ps2_keyboard_rx.md
PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 SHALL have parameter FILTER_CYCLES, default 8: consecutive equal synchronised ps2_clk samples required to accept a level change.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4095: cycles without a filtered falling edge before a partial frame is abandoned.
REQ-003 SHALL have parameter FIFO_AW, default 3: event FIFO depth is 2**FIFO_AW entries.
REQ-004 SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports ps2_clk and ps2_data, input, 1 each, raw asynchronous PS/2 lines.
REQ-007 SHALL have port out_valid, output, 1: FIFO not empty.
REQ-008 SHALL have port out_ready, input, 1: consumer accepts the head entry.
REQ-009 SHALL have port out_code, output, 8: scan code at the FIFO head.
REQ-010 SHALL have ports out_break and out_ext, output, 1 each: head entry was preceded by F0 and/or E0 respectively.
REQ-011 SHALL have ports parity_err, frame_err and overflow, output, 1 each: single-cycle error pulses.
REQ-012 SHALL have port fifo_count, output, FIFO_AW+1: current occupancy.

Function
REQ-013 SHALL pass ps2_clk and ps2_data through two-flop synchronisers before any use.
REQ-014 SHALL change filtered clock only after FILTER_CYCLES consecutive synchronised samples differ from it; any shorter glitch is ignored.
REQ-015 SHALL sample synchronised ps2_data in the cycle a filtered-clock 1->0 transition is detected.
REQ-016 SHALL use FSM states IDLE, DATA, PARITY, STOP; IDLE->DATA on sampled start bit 0; sampled 1 in IDLE is ignored.
REQ-017 SHALL shift 8 data bits LSB first in DATA, then go to PARITY, then STOP.
REQ-018 SHALL check odd parity (8 data bits plus parity bit contain an odd number of ones); mismatch pulses parity_err one cycle after the stop bit sample.
REQ-019 SHALL pulse frame_err one cycle after the stop bit sample when the stop bit is 0; a frame with both faults pulses both.
REQ-020 SHALL return to IDLE after the stop bit sample regardless of errors; errored frames are discarded.
REQ-021 SHALL, outside IDLE, count cycles since the last filtered falling edge; reaching TIMEOUT_CYCLES returns to IDLE and pulses frame_err.
REQ-022 SHALL treat a good byte E0 as setting ext_pend and F0 as setting brk_pend, without writing the FIFO.
REQ-023 SHALL push any other good byte as {code, brk_pend, ext_pend} and clear both pending flags in the same cycle.
REQ-024 SHALL clear both pending flags on any parity error, frame error or timeout.
REQ-025 SHALL push one cycle after the stop bit sample; latency from stop bit sample to out_valid is 2 cycles with the FIFO empty.
REQ-026 SHALL pop when out_valid and out_ready are both 1; out_code/out_break/out_ext show the next entry in the following cycle.
REQ-027 SHALL accept a push when full only if a pop occurs in the same cycle; otherwise drop the entry and pulse overflow.
REQ-028 SHALL leave occupancy unchanged on a simultaneous push and pop; read and write pointers wrap modulo 2**FIFO_AW.
REQ-029 SHALL ignore out_ready while out_valid is 0.

Reset
REQ-030 SHALL, while reset is 1, force FSM to IDLE, clear the shift register, pending flags, timeout counter, FIFO pointers and fifo_count, and drive out_valid, parity_err, frame_err and overflow to 0.
REQ-031 SHALL drive out_code, out_break and out_ext to 0 during reset.
REQ-032 SHALL preload filter and synchroniser state to 1 (idle bus), so releasing reset with ps2_clk high produces no false edge.
REQ-033 SHALL abandon a frame in progress on reset without any error pulse.

Verification
REQ-034 SHALL check: frame for 0x1C with correct parity, out_ready=1 -> one entry out_code=0x1C, out_break=0, out_ext=0, no error pulses.
REQ-035 SHALL check: E0, F0, 0x74 -> exactly one entry out_code=0x74, out_break=1, out_ext=1; fifo_count=1.
REQ-036 SHALL check: frame for 0x1C with parity bit flipped -> parity_err pulse, no entry; following F0 error then 0x1C -> out_break=0.
REQ-037 SHALL check: start bit plus 3 bits, then ps2_clk held high TIMEOUT_CYCLES -> frame_err pulse, FSM IDLE, next good frame received.
REQ-038 SHALL check: FIFO_AW=3, out_ready=0, 9 good codes -> fifo_count=8, one overflow pulse; drain yields first 8 codes in order.
REQ-039 SHALL check: ps2_clk low glitch of FILTER_CYCLES-1 cycles mid-frame -> no bit sampled, frame decodes correctly.
